// File: rtl/ekf_measurement_update.sv
`timescale 1ns/1ps
// ekf_measurement_update: EKF correction step. Latches the predicted state,
// the measured currents and the 4x2 gain, forms the innovations, then runs
// eight multiply-accumulate cycles on a single shared multiplier before the
// final theta wrap. Fixed 10-cycle start-to-done latency.
// Optional build macro EKF_MEAS_SATURATE_EN: saturating arithmetic plus a
// sat_flag output; without it all adds and subtracts wrap in two's complement.
module ekf_measurement_update #(
  parameter int N      = 32,
  parameter int Q      = 18,
  parameter int TWO_PI = 1647099
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] ialphae,
  input  logic signed [N-1:0] ibetae,
  input  logic signed [N-1:0] omegae,
  input  logic signed [N-1:0] thetae,
  input  logic signed [N-1:0] ialpha_meas,
  input  logic signed [N-1:0] ibeta_meas,
  input  logic [8*N-1:0]      K,
  output logic signed [N-1:0] ialpha_c,
  output logic signed [N-1:0] ibeta_c,
  output logic signed [N-1:0] omega_c,
  output logic signed [N-1:0] theta_c,
  output logic signed [N-1:0] innov_alpha,
  output logic signed [N-1:0] innov_beta,
  output logic                busy,
  output logic                done
`ifdef EKF_MEAS_SATURATE_EN
  ,
  output logic                sat_flag
`endif
);

  typedef logic signed [N-1:0]   word_t;
  typedef logic signed [2*N-1:0] wide_t;
  typedef enum logic [1:0] {IDLE, MAC, WRAP, DONE} state_t;

  localparam word_t TWO_PI_W = word_t'(TWO_PI);
  localparam word_t MAX_W    = {1'b0, {(N-1){1'b1}}};
  localparam word_t MIN_W    = {1'b1, {(N-1){1'b0}}};

  state_t     state, state_nx;
  logic [2:0] idx;
  word_t      k_q [8];
  word_t      acc [4];
  word_t      e_a, e_b;
  word_t      mul_q, acc_next, ea_next, eb_next, theta_fix;

`ifdef EKF_MEAS_SATURATE_EN
  logic sat_acc;
  logic mac_ovf, ea_ovf, eb_ovf, th_ovf;

  function automatic logic add_ovf(input word_t a, input word_t b);
    word_t s;
    s = a + b;
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  function automatic logic sub_ovf(input word_t a, input word_t b);
    word_t s;
    s = a - b;
    return (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  function automatic word_t add_s(input word_t a, input word_t b);
    if (add_ovf(a, b)) return a[N-1] ? MIN_W : MAX_W;
    return a + b;
  endfunction

  function automatic word_t sub_s(input word_t a, input word_t b);
    if (sub_ovf(a, b)) return a[N-1] ? MIN_W : MAX_W;
    return a - b;
  endfunction
`else
  function automatic word_t add_s(input word_t a, input word_t b);
    return a + b;
  endfunction

  function automatic word_t sub_s(input word_t a, input word_t b);
    return a - b;
  endfunction
`endif

  // State register for the correction sequencer.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: IDLE waits for start, MAC runs eight products, then WRAP and DONE.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (idx == 3'd7) state_nx = WRAP;
      WRAP:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared multiplier, accumulate, innovation and theta-wrap arithmetic.
  always_comb begin
    // NOTE: combinational temporaries use blocking '='; registers below use '<='.
    mul_q     = word_t'((wide_t'(k_q[idx]) * wide_t'(idx[0] ? e_b : e_a)) >>> Q);
    acc_next  = add_s(acc[idx[2:1]], mul_q);
    ea_next   = sub_s(ialpha_meas, ialphae);
    eb_next   = sub_s(ibeta_meas, ibetae);
    theta_fix = acc[3];
    if (acc[3] >= TWO_PI_W)  theta_fix = sub_s(acc[3], TWO_PI_W);
    else if (acc[3][N-1])    theta_fix = add_s(acc[3], TWO_PI_W);
`ifdef EKF_MEAS_SATURATE_EN
    mac_ovf = add_ovf(acc[idx[2:1]], mul_q);
    ea_ovf  = sub_ovf(ialpha_meas, ialphae);
    eb_ovf  = sub_ovf(ibeta_meas, ibetae);
    th_ovf  = 1'b0;
    if (acc[3] >= TWO_PI_W) th_ovf = sub_ovf(acc[3], TWO_PI_W);
    else if (acc[3][N-1])   th_ovf = add_ovf(acc[3], TWO_PI_W);
`endif
  end

  // Gain capture on an accepted start.
  always_ff @(posedge clk) begin
    // NOTE: the gain bank carries no reset; it is always loaded before the MAC phase reads it.
    if (state == IDLE && start) begin
      for (int i = 0; i < 8; i++) k_q[i] <= K[i*N +: N];
    end
  end

  // Datapath registers: capture, accumulate, publish results and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      idx         <= '0;
      e_a         <= '0;
      e_b         <= '0;
      ialpha_c    <= '0;
      ibeta_c     <= '0;
      omega_c     <= '0;
      theta_c     <= '0;
      innov_alpha <= '0;
      innov_beta  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef EKF_MEAS_SATURATE_EN
      sat_acc     <= 1'b0;
      sat_flag    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          e_a    <= ea_next;
          e_b    <= eb_next;
          acc[0] <= ialphae;
          acc[1] <= ibetae;
          acc[2] <= omegae;
          acc[3] <= thetae;
          idx    <= '0;
          busy   <= 1'b1;
`ifdef EKF_MEAS_SATURATE_EN
          sat_acc  <= ea_ovf | eb_ovf;
          sat_flag <= 1'b0;
`endif
        end
        MAC: begin
          acc[idx[2:1]] <= acc_next;
          idx           <= idx + 3'd1;
`ifdef EKF_MEAS_SATURATE_EN
          sat_acc <= sat_acc | mac_ovf;
`endif
        end
        WRAP: begin
          ialpha_c    <= acc[0];
          ibeta_c     <= acc[1];
          omega_c     <= acc[2];
          theta_c     <= theta_fix;
          innov_alpha <= e_a;
          innov_beta  <= e_b;
`ifdef EKF_MEAS_SATURATE_EN
          sat_acc <= sat_acc | th_ovf;
`endif
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
`ifdef EKF_MEAS_SATURATE_EN
          sat_flag <= sat_acc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ekf_measurement_update.md
Name: ekf_measurement_update

Overview:
- Correction half of the EKF loop. Consumes the predicted state from the prediction stage (ialphae, ibetae, omegae, thetae) and the measured alpha/beta currents.
- Computes innovation = measured - predicted, then corrected state = predicted + K*innovation, using a 4x2 Kalman gain supplied by the covariance stage.
- Uses one time-multiplexed fixed-point multiplier over 8 cycles, with a start/done handshake. Output feeds back to the prediction stage on the next sample.

Parameters:
- N, 32, word width (signed fixed point).
- Q, 18, fractional bits; 1.0 = 2^Q = 262144.
- TWO_PI, 1647099, round(2*pi*2^Q), theta wrap modulus.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one correction; sampled only in IDLE.
- ialphae, ibetae, omegae, thetae  input  N each  predicted state, Q-format.
- ialpha_meas, ibeta_meas  input  N each  measured currents, Q-format.
- K  input  8*N  gain matrix; element (r,c) at bits [(2r+c)*N +: N]. Rows r: 0=ialpha, 1=ibeta, 2=omega, 3=theta. Columns c: 0=alpha innovation, 1=beta innovation.
- ialpha_c, ibeta_c, omega_c, theta_c  output  N each  corrected state, registered.
- innov_alpha, innov_beta  output  N each  registered innovations.
- busy  output  1  high while a correction is in flight.
- done  output  1  one-cycle pulse; corrected outputs valid from this cycle.

Behaviour:
- Reset, and reset asserted at any point mid-operation: all outputs 0, busy=0, done=0, state=IDLE, accumulators cleared. Any partial result is discarded.
- FSM states: IDLE, MAC, WRAP, DONE.
- IDLE:
  - On the edge where start=1, latch all state, measurement and K inputs.
  - Compute innovations e_a = ialpha_meas - ialphae and e_b = ibeta_meas - ibetae.
  - Preload accumulator row r with the predicted state r. Set idx=0, busy=1, go to MAC.
- MAC: 8 cycles, idx 0..7, with r=idx>>1 and c=idx&1.
  - Each cycle: acc[r] += mult(K[r][c], e[c]).
  - After idx=7, go to WRAP.
- Multiply rule: full 2N-bit signed product, result = product bits [N-1+Q : Q]. This is an arithmetic shift, truncating toward minus infinity. No rounding.
- Addition rule: N-bit two's-complement wrap, unless SATURATE_EN is defined.
- WRAP: single correction of acc[3].
  - If acc[3] >= TWO_PI, subtract TWO_PI.
  - Else if acc[3] < 0, add TWO_PI.
  - Register all outputs and innovations, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Timing: start sampled at edge k gives done high in the cycle after edge k+10. Fixed latency of 10 cycles.
- Outputs hold their last values until the next DONE.
- start while busy=1 is ignored; it is not queued.
- A new start may be sampled in the IDLE cycle immediately following DONE, giving a throughput of 1 correction per 11 cycles.
- Inputs may change after the start edge without affecting the result.
- Omega is not wrapped. Theta inputs are required to be within [0, TWO_PI); outputs are only guaranteed in range when the correction magnitude is below TWO_PI.

Optional Feature:
- Macro: EKF_MEAS_SATURATE_EN.
- Defined: the innovation subtractions, every accumulate, and the TWO_PI add/subtract saturate to [-2^(N-1), 2^(N-1)-1]. Registered output sat_flag (1 bit) goes high at DONE if any saturation occurred in that correction; it is cleared on the next start.
- Undefined: two's-complement wrap everywhere, and no sat_flag port.

Test Plan:
- K00=K11=262144, all other K=0; ialphae=262144, ialpha_meas=393216; ibetae=ibeta_meas=0; omegae=1000; thetae=5000; start at edge k -> done only in the cycle after k+10; ialpha_c=393216, innov_alpha=131072, ibeta_c=0, omega_c=1000, theta_c=5000.
- Positive theta wrap: K30=262144, others 0; thetae=1646999, ialphae=0, ialpha_meas=200 -> theta_c=100.
- Negative theta wrap and truncation: K31=262144; thetae=50, ibetae=0, ibeta_meas=-300 -> theta_c=1646849. With K21=131072 and e_b=-3 -> omega contribution = -2, confirming truncation toward minus infinity.
- start re-asserted on every cycle while busy -> exactly one done per 11 cycles; results correspond only to inputs latched at the accepted start edge.
- reset asserted 4 cycles after start -> next cycle shows all outputs 0, busy=0, and no done pulse. A fresh start then completes normally in 10 cycles.
- With EKF_MEAS_SATURATE_EN: ialphae=-2^31, ialpha_meas=2^31-1 -> innov_alpha=2147483647 and sat_flag=1. Without the macro -> innov_alpha=-1 (wrapped).
